// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per cycle through an external 4-bit ripple adder.
// Optional signed-overflow output OUT_OVF is enabled with `define NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_a,
   input  logic [4*NIBBLES-1:0] in_b,
   input  logic                 in_cin,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_sum,
   input  logic                 add_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_sum,
   output logic                 out_cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,
   output logic                 out_ovf
`endif
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    a_q, b_q, res_q, res_nxt;
   logic            cin_q, carry_q;
   logic [IW-1:0]   idx_q;
   logic            last;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = 4'h0;
      add_b     = 4'h0;
      add_cin   = 1'b0;
      res_nxt   = res_q;
      last      = (idx_q == IW'(NIBBLES - 1));
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            // The adder is combinational, so its sum lands in the nibble being presented.
            add_a   = a_q[4*idx_q +: 4];
            add_b   = b_q[4*idx_q +: 4];
            add_cin = (idx_q == '0) ? cin_q : carry_q;
            res_nxt[4*idx_q +: 4] = add_sum;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         out_ovf  <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  cin_q <= in_cin;
                  idx_q <= '0;
                  res_q <= '0;
               end
            end
            RUN: begin
               res_q   <= res_nxt;
               carry_q <= add_cout;
               idx_q   <= idx_q + IW'(1);
               if (last) begin
                  // Outputs only change on DONE entry so they hold across the next transaction.
                  idx_q    <= '0;
                  out_sum  <= res_nxt;
                  out_cout <= add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                  out_ovf  <= (a_q[W-1] == b_q[W-1]) && (res_nxt[W-1] != a_q[W-1]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
